// File: rtl/alu_share_if.sv
// alu_share_if
//   Bundles the request, ALU and response signals of the shared-ALU controller.
//   The slave modport is the controller's view. The master modport is the
//   environment's view: the requesters, the ALU and the response consumer.
//   Signals:
//     req_valid/req_ready   per-requester handshake, bit i = requester i
//     req{0,1}_a/_b/_op     requester operands and opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//     alu_a/alu_b/alu_op    registered operands/opcode driven to the ALU
//     alu_res/alu_flags     ALU result and {C,V,Z,N}
//     rsp_*                 response channel (valid/ready, result, flags, source)
//     busy                  controller is executing or holding a response
interface alu_share_if #(
   parameter int W = 7
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic [1:0]   req0_op;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic [1:0]   req1_op;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_res;
   logic [3:0]   alu_flags;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_res;
   logic [3:0]   rsp_flags;
   logic         rsp_src;
   logic         busy;

   modport slave (
      input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
      input  alu_res, alu_flags, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op,
      output rsp_valid, rsp_res, rsp_flags, rsp_src, busy
   );

   modport master (
      output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
      output alu_res, alu_flags, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op,
      input  rsp_valid, rsp_res, rsp_flags, rsp_src, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Round-robin controller time-sharing one W-bit ALU between two requesters.
//   A granted request is latched onto the ALU inputs. After EXEC_CYCLES settle
//   cycles the ALU result and flags are captured. They are then offered on the
//   response channel, tagged with the requester that issued the op.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    alu_share_if slave modport (request, ALU and response signals)
//   Parameters:
//     W            operand/result width; must match the ALU
//     EXEC_CYCLES  ALU settle cycles before capture, 1..15
module alu_share_ctrl #(
   parameter int W           = 7,
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   alu_share_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t       state_q, state_d;
   logic         ptr_q, ptr_d;
   logic         src_q, src_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [W-1:0] alu_a_q, alu_a_d;
   logic [W-1:0] alu_b_q, alu_b_d;
   logic [1:0]   alu_op_q, alu_op_d;
   logic [W-1:0] rsp_res_q, rsp_res_d;
   logic [3:0]   rsp_flags_q, rsp_flags_d;
   logic         rsp_valid_q, rsp_valid_d;

   logic         gnt;
   logic [1:0]   req_ready_c;
   logic         accept;

   // Grant selection: a lone requester wins outright, a tie goes to ptr.
   // req_ready is masked by reset so every output reads 0 while reset is held.
   always_comb begin
      gnt         = bus.req_valid[1];
      req_ready_c = 2'b00;
      if (bus.req_valid == 2'b11) begin
         gnt = ptr_q;
      end
      if (state_q == IDLE && !reset && bus.req_valid[gnt]) begin
         req_ready_c = gnt ? 2'b10 : 2'b01;
      end
   end

   assign accept = |(bus.req_valid & req_ready_c);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      src_d       = src_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_res_d   = rsp_res_q;
      rsp_flags_d = rsp_flags_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d  = gnt ? bus.req1_a  : bus.req0_a;
               alu_b_d  = gnt ? bus.req1_b  : bus.req0_b;
               alu_op_d = gnt ? bus.req1_op : bus.req0_op;
               src_d    = gnt;
               cnt_d    = CNT_INIT;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_res_d   = bus.alu_res;
               rsp_flags_d = bus.alu_flags;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               // Hand priority to the other requester so continuous contention alternates.
               ptr_d       = ~src_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         src_q       <= 1'b0;
         cnt_q       <= 4'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 2'b00;
         rsp_res_q   <= '0;
         rsp_flags_q <= 4'd0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         src_q       <= src_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_res_q   <= rsp_res_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_src   = src_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
